// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline hazard/forwarding control.
//   fwd_sel_e   : EX operand mux select encoding
//   sb_slot_t   : one in-flight scoreboard entry (EX, MEM or WB)
//   REG_ZERO    : hard-wired zero register specifier
package mips_pkg;

  localparam int unsigned SB_DEST_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [SB_DEST_W-1:0] dest;
    logic                 we;
    logic                 load;
  } sb_slot_t;

  localparam logic [SB_DEST_W-1:0] REG_ZERO = '0;

  // Newest producer wins: the EX-slot result is younger than the MEM-slot one.
  function automatic fwd_sel_e fwd_pick(input logic use_src, input logic ex_hit,
                                        input logic mem_hit);
    fwd_sel_e sel;
    sel = FWD_RF;
    if (use_src) begin
      if (ex_hit) begin
        sel = FWD_MEM;
      end else if (mem_hit) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_slot_cmp.sv
// Compares one scoreboard slot against one source specifier.
//   slot_i       : scoreboard entry
//   src_i        : source register specifier
//   match_o      : slot is a valid writer of src_i (never for $0)
//   load_match_o : match_o and the producer is a load
module hazard_slot_cmp
  import mips_pkg::*;
#(
  parameter int unsigned REG_W = SB_DEST_W
) (
  input  sb_slot_t         slot_i,
  input  logic [REG_W-1:0] src_i,
  output logic             match_o,
  output logic             load_match_o
);

  logic [SB_DEST_W-1:0] src_w;

  assign src_w        = SB_DEST_W'(src_i);
  assign match_o      = slot_i.valid & slot_i.we & (slot_i.dest == src_w) &
                        (src_w != REG_ZERO);
  assign load_match_o = match_o & slot_i.load;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and forwarding control for the five-stage MIPS pipeline.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   ext_stall           : global freeze, holds everything but the mult/div counter
//   id_*                : decoded information of the instruction in ID
//   id_stall            : hold PC and IF/ID (combinational)
//   ex_bubble           : load a NOP into ID/EX (combinational)
//   fwd_a_sel/fwd_b_sel : EX operand mux selects (registered)
//   md_busy             : mult/div result not yet available
module hazard_fwd_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MD_CYCLES = 4,
  parameter int unsigned REG_W     = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ext_stall,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dest,
  input  logic             id_reg_we,
  input  logic             id_is_load,
  input  logic             id_is_md,
  input  logic             id_reads_hilo,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             md_busy
);

  localparam int unsigned MD_W = $clog2(MD_CYCLES + 1);

  sb_slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  fwd_sel_e sel_a_q, sel_a_d, sel_b_q, sel_b_d;
  logic [MD_W-1:0] md_cnt_q, md_cnt_d;

  logic ex_hit_a, ex_hit_b, ex_ld_a, ex_ld_b;
  logic mem_hit_a, mem_hit_b;
  logic unused_mem_ld_a, unused_mem_ld_b;
  logic unused_wb_hit_a, unused_wb_hit_b, unused_wb_ld_a, unused_wb_ld_b;

  logic md_busy_raw, load_use, hilo_haz, stall_raw, md_accept;

  // Slot comparators: EX and MEM feed forwarding; WB is tracked but the
  // register file's write-before-read makes its matches irrelevant.
  hazard_slot_cmp #(.REG_W(REG_W)) u_cmp_ex_a (
    .slot_i(ex_q), .src_i(id_rs), .match_o(ex_hit_a), .load_match_o(ex_ld_a));
  hazard_slot_cmp #(.REG_W(REG_W)) u_cmp_ex_b (
    .slot_i(ex_q), .src_i(id_rt), .match_o(ex_hit_b), .load_match_o(ex_ld_b));
  hazard_slot_cmp #(.REG_W(REG_W)) u_cmp_mem_a (
    .slot_i(mem_q), .src_i(id_rs), .match_o(mem_hit_a), .load_match_o(unused_mem_ld_a));
  hazard_slot_cmp #(.REG_W(REG_W)) u_cmp_mem_b (
    .slot_i(mem_q), .src_i(id_rt), .match_o(mem_hit_b), .load_match_o(unused_mem_ld_b));
  hazard_slot_cmp #(.REG_W(REG_W)) u_cmp_wb_a (
    .slot_i(wb_q), .src_i(id_rs), .match_o(unused_wb_hit_a), .load_match_o(unused_wb_ld_a));
  hazard_slot_cmp #(.REG_W(REG_W)) u_cmp_wb_b (
    .slot_i(wb_q), .src_i(id_rt), .match_o(unused_wb_hit_b), .load_match_o(unused_wb_ld_b));

  // Hazard detection
  assign md_busy_raw = (md_cnt_q != '0);
  assign load_use    = id_valid & ((id_use_rs & ex_ld_a) | (id_use_rt & ex_ld_b));
  assign hilo_haz    = id_valid & (id_reads_hilo | id_is_md) & md_busy_raw;
  assign stall_raw   = load_use | hilo_haz;
  assign md_accept   = id_valid & ~stall_raw & ~ext_stall & id_is_md;

  // Stall outputs are suppressed while reset is asserted
  assign id_stall  = rst_n & stall_raw;
  assign ex_bubble = id_stall & ~ext_stall;
  assign md_busy   = rst_n & md_busy_raw;
  assign fwd_a_sel = sel_a_q;
  assign fwd_b_sel = sel_b_q;

  // Scoreboard advance and select computation
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_q;
    wb_d    = wb_q;
    sel_a_d = sel_a_q;
    sel_b_d = sel_b_q;
    if (!ext_stall) begin
      ex_d = '0;
      if (id_valid && !stall_raw) begin
        ex_d.valid = 1'b1;
        ex_d.dest  = SB_DEST_W'(id_dest);
        ex_d.we    = id_reg_we;
        ex_d.load  = id_is_load;
      end
      mem_d = ex_q;
      wb_d  = mem_q;
      // A stalled ID sends a bubble into EX, which needs no forwarding
      sel_a_d = stall_raw ? FWD_RF : fwd_pick(id_use_rs, ex_hit_a, mem_hit_a);
      sel_b_d = stall_raw ? FWD_RF : fwd_pick(id_use_rt, ex_hit_b, mem_hit_b);
    end
  end

  // Mult/div counter runs independently of the global freeze
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_busy_raw) begin
      md_cnt_d = md_cnt_q - MD_W'(1);
    end
    if (md_accept) begin
      md_cnt_d = MD_W'(MD_CYCLES);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      sel_a_q  <= FWD_RF;
      sel_b_q  <= FWD_RF;
      md_cnt_q <= '0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule
